// File: rtl/axi4_sram_slave_if.sv
// AXI4 bus bundle between an LSU/IFU master and the on-chip SRAM responder.
interface axi4_sram_slave_if;
  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic [3:0]  awid;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;
  logic [3:0]  bid;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic [3:0]  rid;

  modport master (
    output awvalid, awaddr, awid, awlen, awsize, awburst,
    output wvalid, wdata, wstrb, wlast, bready,
    output arvalid, araddr, arid, arlen, arsize, arburst, rready,
    input  awready, wready, bvalid, bresp, bid,
    input  arready, rvalid, rdata, rresp, rlast, rid
  );

  modport slave (
    input  awvalid, awaddr, awid, awlen, awsize, awburst,
    input  wvalid, wdata, wstrb, wlast, bready,
    input  arvalid, araddr, arid, arlen, arsize, arburst, rready,
    output awready, wready, bvalid, bresp, bid,
    output arready, rvalid, rdata, rresp, rlast, rid
  );
endinterface

// File: rtl/axi4_sram_slave.sv
// AXI4 responder in front of a word-addressed SRAM, one transaction in flight.
// Optional AXI_SLV_RANGE_CHECK_EN: out-of-window beats get SLVERR, zero data, no write.
module axi4_sram_slave #(
  parameter int unsigned ADDR_W     = 16,
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
  parameter int unsigned RD_LATENCY = 1
) (
  input logic              clock,
  input logic              reset,
  axi4_sram_slave_if.slave bus
);
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_R_LAT  = 3'd1;
  localparam logic [2:0] ST_R_DATA = 3'd2;
  localparam logic [2:0] ST_W_DATA = 3'd3;
  localparam logic [2:0] ST_W_RESP = 3'd4;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [7:0] LAT_LAST    = 8'((RD_LATENCY == 0) ? 0 : RD_LATENCY - 1);

  logic [31:0] mem_r [0:(2**ADDR_W)-1];
  logic [2:0]  state_r;
  logic        prio_read_r;
  logic [31:0] addr_r;
  logic [7:0]  len_r, beat_r, lat_r;
  logic [2:0]  size_r;
  logic [1:0]  burst_r;
  logic        slverr_r;
  logic        wready_r, bvalid_r, rvalid_r, rlast_r;
  logic [1:0]  bresp_r, rresp_r;
  logic [3:0]  bid_r, rid_r;
  logic [31:0] rdata_r;

  logic        grant_read_s, ar_hs_s, aw_hs_s, w_hs_s, r_hs_s, beat_last_s;
  logic        rd_ok_s, wr_ok_s, mem_we_s, wlast_err_s;
  logic [31:0] next_addr_s, rd_addr_s, rd_data_s;
  logic [1:0]  rd_resp_s;

  function automatic logic [ADDR_W-1:0] word_idx(input logic [31:0] byte_addr);
    return ADDR_W'((byte_addr - BASE_ADDR) >> 2);
  endfunction

`ifdef AXI_SLV_RANGE_CHECK_EN
  function automatic logic in_range(input logic [31:0] byte_addr);
    return ((byte_addr - BASE_ADDR) >> (ADDR_W + 2)) == 32'd0;
  endfunction
  assign rd_ok_s = in_range(rd_addr_s);
  assign wr_ok_s = in_range(addr_r);
`else
  assign rd_ok_s = 1'b1;
  assign wr_ok_s = 1'b1;
`endif

  // Arbitration, handshake decode and next-beat address
  always_comb begin
    grant_read_s = bus.arvalid & (~bus.awvalid | prio_read_r);
    if ((state_r == ST_IDLE) && !reset) begin
      ar_hs_s = grant_read_s;
      aw_hs_s = bus.awvalid & ~grant_read_s;
    end else begin
      ar_hs_s = 1'b0;
      aw_hs_s = 1'b0;
    end
    w_hs_s      = wready_r & bus.wvalid;
    r_hs_s      = rvalid_r & bus.rready;
    beat_last_s = (beat_r == len_r);
    wlast_err_s = (bus.wlast != beat_last_s);
    if (burst_r == BURST_FIXED) begin
      next_addr_s = addr_r;
    end else begin
      next_addr_s = addr_r + (32'd1 << size_r);
    end
    // IDLE reads ahead for zero latency; R_DATA reads ahead for back-to-back beats
    case (state_r)
      ST_IDLE:   rd_addr_s = bus.araddr;
      ST_R_DATA: rd_addr_s = next_addr_s;
      default:   rd_addr_s = addr_r;
    endcase
    if (rd_ok_s) begin
      rd_data_s = mem_r[word_idx(rd_addr_s)];
      rd_resp_s = RESP_OKAY;
    end else begin
      rd_data_s = 32'd0;
      rd_resp_s = RESP_SLVERR;
    end
    mem_we_s = w_hs_s & wr_ok_s & ~reset;
  end

  // SRAM byte-enable write port; contents survive reset
  always_ff @(posedge clock) begin
    if (mem_we_s) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.wstrb[b]) mem_r[word_idx(addr_r)][8*b +: 8] <= bus.wdata[8*b +: 8];
      end
    end
  end

  // Transaction FSM and registered response channels
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      prio_read_r <= 1'b1;
      addr_r      <= 32'd0;
      len_r       <= 8'd0;
      beat_r      <= 8'd0;
      lat_r       <= 8'd0;
      size_r      <= 3'd0;
      burst_r     <= 2'd0;
      slverr_r    <= 1'b0;
      wready_r    <= 1'b0;
      bvalid_r    <= 1'b0;
      bresp_r     <= 2'd0;
      bid_r       <= 4'd0;
      rvalid_r    <= 1'b0;
      rdata_r     <= 32'd0;
      rresp_r     <= 2'd0;
      rlast_r     <= 1'b0;
      rid_r       <= 4'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (ar_hs_s) begin
            addr_r      <= bus.araddr;
            len_r       <= bus.arlen;
            size_r      <= bus.arsize;
            burst_r     <= bus.arburst;
            rid_r       <= bus.arid;
            beat_r      <= 8'd0;
            lat_r       <= 8'd0;
            prio_read_r <= 1'b0;
            if (RD_LATENCY == 0) begin
              state_r  <= ST_R_DATA;
              rvalid_r <= 1'b1;
              rdata_r  <= rd_data_s;
              rresp_r  <= rd_resp_s;
              rlast_r  <= (bus.arlen == 8'd0);
            end else begin
              state_r <= ST_R_LAT;
            end
          end else if (aw_hs_s) begin
            addr_r      <= bus.awaddr;
            len_r       <= bus.awlen;
            size_r      <= bus.awsize;
            burst_r     <= bus.awburst;
            bid_r       <= bus.awid;
            beat_r      <= 8'd0;
            slverr_r    <= 1'b0;
            wready_r    <= 1'b1;
            prio_read_r <= 1'b1;
            state_r     <= ST_W_DATA;
          end
        end
        ST_R_LAT: begin
          if (lat_r == LAT_LAST) begin
            state_r  <= ST_R_DATA;
            rvalid_r <= 1'b1;
            rdata_r  <= rd_data_s;
            rresp_r  <= rd_resp_s;
            rlast_r  <= (len_r == 8'd0);
          end else begin
            lat_r <= lat_r + 8'd1;
          end
        end
        ST_R_DATA: begin
          if (r_hs_s) begin
            if (beat_last_s) begin
              rvalid_r <= 1'b0;
              rlast_r  <= 1'b0;
              state_r  <= ST_IDLE;
            end else begin
              addr_r  <= next_addr_s;
              beat_r  <= beat_r + 8'd1;
              rdata_r <= rd_data_s;
              rresp_r <= rd_resp_s;
              rlast_r <= ((beat_r + 8'd1) == len_r);
            end
          end
        end
        ST_W_DATA: begin
          if (w_hs_s) begin
            if (beat_last_s) begin
              wready_r <= 1'b0;
              bvalid_r <= 1'b1;
              bresp_r  <= (slverr_r | wlast_err_s | ~wr_ok_s) ? RESP_SLVERR : RESP_OKAY;
              state_r  <= ST_W_RESP;
            end else begin
              addr_r   <= next_addr_s;
              beat_r   <= beat_r + 8'd1;
              slverr_r <= slverr_r | wlast_err_s | ~wr_ok_s;
            end
          end
        end
        ST_W_RESP: begin
          if (bus.bready) begin
            bvalid_r <= 1'b0;
            bresp_r  <= 2'd0;
            state_r  <= ST_IDLE;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  assign bus.arready = ar_hs_s;
  assign bus.awready = aw_hs_s;
  assign bus.wready  = wready_r;
  assign bus.bvalid  = bvalid_r;
  assign bus.bresp   = bresp_r;
  assign bus.bid     = bid_r;
  assign bus.rvalid  = rvalid_r;
  assign bus.rdata   = rdata_r;
  assign bus.rresp   = rresp_r;
  assign bus.rlast   = rlast_r;
  assign bus.rid     = rid_r;
endmodule
